// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared types and constants for the branch redirect controller
package branch_ctrl_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } redir_state_e;

  // Word-aligned targets are the only ones the fetch unit can take.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  // Clear has priority so a coincident event is dropped, not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - PC redirect and flush sequencer for control transfers resolved in EX
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_ctrl,
  input  logic             branch_or_not,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             pipe_stall,
  input  logic             clr_stats,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             busy,
  output logic             misalign_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 7)) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..7");
  end

  redir_state_e    state_q;
  logic [2:0]      flush_cnt_q;
  logic [XLEN-1:0] pc_target_q;
  logic            pc_sel_q;
  logic            flush_ifid_q;
  logic            flush_idex_q;
  logic            busy_q;
  logic            misalign_q;

  logic acc;
  logic taken_ok;
  logic taken_bad;

  // Instructions arriving while a sequence runs are squashed bubbles.
  assign acc       = (state_q == ST_IDLE) & ex_valid & ex_is_ctrl & ~pipe_stall;
  assign taken_ok  = acc & branch_or_not & is_aligned(ex_target[1:0]);
  assign taken_bad = acc & branch_or_not & ~is_aligned(ex_target[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= 3'd0;
      pc_target_q  <= '0;
      pc_sel_q     <= 1'b0;
      flush_ifid_q <= 1'b0;
      flush_idex_q <= 1'b0;
      busy_q       <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= taken_bad;
      case (state_q)
        ST_IDLE: begin
          if (taken_ok) begin
            pc_target_q  <= ex_target;
            state_q      <= ST_REDIRECT;
            pc_sel_q     <= 1'b1;
            flush_ifid_q <= 1'b1;
            flush_idex_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (!pipe_stall) begin
            pc_sel_q     <= 1'b0;
            flush_idex_q <= 1'b0;
            if (FLUSH_CYCLES == 1) begin
              state_q      <= ST_IDLE;
              flush_ifid_q <= 1'b0;
              busy_q       <= 1'b0;
            end else begin
              flush_cnt_q <= FLUSH_LOAD;
              state_q     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // The counter holds the FLUSH cycles still to run, this one included.
          if (!pipe_stall) begin
            if (flush_cnt_q <= 3'd1) begin
              flush_cnt_q  <= 3'd0;
              state_q      <= ST_IDLE;
              flush_ifid_q <= 1'b0;
              busy_q       <= 1'b0;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          flush_cnt_q  <= 3'd0;
          pc_sel_q     <= 1'b0;
          flush_ifid_q <= 1'b0;
          flush_idex_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (acc),
    .clr   (clr_stats),
    .cnt   (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken_ok),
    .clr   (clr_stats),
    .cnt   (taken_cnt)
  );

  assign pc_sel       = pc_sel_q;
  assign pc_target    = pc_target_q;
  assign flush_ifid   = flush_ifid_q;
  assign flush_idex   = flush_idex_q;
  assign busy         = busy_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl at three flush lengths
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int NDUT  = 3;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic            clk;
  logic            rst_n;
  logic            ex_valid;
  logic            ex_is_ctrl;
  logic            branch_or_not;
  logic [XLEN-1:0] ex_target;
  logic            pipe_stall;
  logic            clr_stats;

  logic [NDUT-1:0] pc_sel_w;
  logic [NDUT-1:0] ifid_w;
  logic [NDUT-1:0] idex_w;
  logic [NDUT-1:0] busy_w;
  logic [NDUT-1:0] mis_w;
  logic [XLEN-1:0] tgt_w  [NDUT];
  logic [CNT_W-1:0] bcnt_w [NDUT];
  logic [CNT_W-1:0] tcnt_w [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    branch_redirect_ctrl #(
      .XLEN         (XLEN),
      .FLUSH_CYCLES (g + 1),
      .CNT_W        (CNT_W)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_is_ctrl    (ex_is_ctrl),
      .branch_or_not (branch_or_not),
      .ex_target     (ex_target),
      .pipe_stall    (pipe_stall),
      .clr_stats     (clr_stats),
      .pc_sel        (pc_sel_w[g]),
      .pc_target     (tgt_w[g]),
      .flush_ifid    (ifid_w[g]),
      .flush_idex    (idex_w[g]),
      .busy          (busy_w[g]),
      .misalign_err  (mis_w[g]),
      .branch_cnt    (bcnt_w[g]),
      .taken_cnt     (tcnt_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: remaining unstalled busy cycles, and whether the first one is still pending.
  int          m_busy  [NDUT];
  bit          m_first [NDUT];
  logic [31:0] m_tgt   [NDUT];
  bit          m_mis   [NDUT];
  int          m_bc    [NDUT];
  int          m_tc    [NDUT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_busy[d] = 0; m_first[d] = 0; m_tgt[d] = '0; m_mis[d] = 0; m_bc[d] = 0; m_tc[d] = 0;
    end
  endtask

  task automatic model_step();
    bit idle, acc, ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < NDUT; d++) begin
      idle = (m_busy[d] == 0);
      acc  = idle && ex_valid && ex_is_ctrl && !pipe_stall;
      ok   = acc && branch_or_not && (ex_target % 4 == 0);
      m_mis[d] = acc && branch_or_not && (ex_target % 4 != 0);
      if (!idle) begin
        if (!pipe_stall) begin
          m_busy[d]--;
          m_first[d] = 0;
        end
      end else if (ok) begin
        m_busy[d]  = d + 1;
        m_first[d] = 1;
        m_tgt[d]   = ex_target;
      end
      if (clr_stats) begin
        m_bc[d] = 0;
        m_tc[d] = 0;
      end else begin
        if (acc && m_bc[d] < SAT) m_bc[d]++;
        if (ok && m_tc[d] < SAT) m_tc[d]++;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("fc%0d_pc_sel", d + 1), 32'(pc_sel_w[d]), 32'(m_busy[d] > 0 && m_first[d]));
      check($sformatf("fc%0d_flush_idex", d + 1), 32'(idex_w[d]), 32'(m_busy[d] > 0 && m_first[d]));
      check($sformatf("fc%0d_flush_ifid", d + 1), 32'(ifid_w[d]), 32'(m_busy[d] > 0));
      check($sformatf("fc%0d_busy", d + 1), 32'(busy_w[d]), 32'(m_busy[d] > 0));
      check($sformatf("fc%0d_misalign", d + 1), 32'(mis_w[d]), 32'(m_mis[d]));
      check($sformatf("fc%0d_pc_target", d + 1), tgt_w[d], m_tgt[d]);
      check($sformatf("fc%0d_branch_cnt", d + 1), 32'(bcnt_w[d]), 32'(m_bc[d]));
      check($sformatf("fc%0d_taken_cnt", d + 1), 32'(tcnt_w[d]), 32'(m_tc[d]));
    end
  endtask

  task automatic drive(input bit v, input bit c, input bit b, input logic [31:0] t,
                       input bit s, input bit clr);
    ex_valid = v; ex_is_ctrl = c; branch_or_not = b; ex_target = t;
    pipe_stall = s; clr_stats = clr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;
    logic [31:0] t;
    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Taken beq to 0x40
    drive(1, 1, 1, 32'h40, 0, 0); cycle();
    check("beq_pc_sel", 32'(pc_sel_w[1]), 32'd1);
    check("beq_target", tgt_w[1], 32'h40);
    check("beq_idex", 32'(idex_w[1]), 32'd1);
    drive(0, 0, 0, 32'h0, 0, 0); cycle();
    check("beq_flush_only_ifid", {30'd0, ifid_w[1], pc_sel_w[1] | idex_w[1]}, 32'd2);
    cycle();
    check("beq_busy_done", 32'(busy_w[1]), 32'd0);
    check("beq_bcnt", 32'(bcnt_w[1]), 32'd1);
    check("beq_tcnt", 32'(tcnt_w[1]), 32'd1);

    // Not-taken bne
    drive(1, 1, 0, 32'h80, 0, 0); cycle();
    check("bne_busy", 32'(busy_w[1]), 32'd0);
    check("bne_bcnt", 32'(bcnt_w[1]), 32'd2);
    check("bne_tcnt", 32'(tcnt_w[1]), 32'd1);
    drive(0, 0, 0, 32'h0, 0, 0); repeat (3) cycle();

    // Stall right after accept stretches the sequence
    drive(1, 1, 1, 32'h100, 0, 0); cycle();
    n = busy_w[1] ? 1 : 0;
    drive(1, 1, 1, 32'h200, 1, 0);
    repeat (3) begin
      cycle();
      if (busy_w[1]) n++;
      check("stall_pc_sel_held", 32'(pc_sel_w[1]), 32'd1);
    end
    drive(0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (busy_w[1]) n++;
      else break;
    end
    check("stall_busy_cycles", n, 5);
    check("stall_tcnt", 32'(tcnt_w[1]), 32'd2);
    repeat (3) cycle();

    // Misaligned taken target
    drive(1, 1, 1, 32'h42, 0, 0); cycle();
    check("mis_pulse", 32'(mis_w[1]), 32'd1);
    check("mis_no_pc_sel", 32'(pc_sel_w[1]), 32'd0);
    drive(0, 0, 0, 32'h0, 0, 0); cycle();
    check("mis_pulse_end", 32'(mis_w[1]), 32'd0);
    check("mis_bcnt", 32'(bcnt_w[1]), 32'd4);
    check("mis_tcnt", 32'(tcnt_w[1]), 32'd2);

    // Saturation with back-to-back taken jal
    drive(1, 1, 1, 32'h300, 0, 0);
    repeat (70) cycle();
    check("sat_tcnt", 32'(tcnt_w[1]), 32'(SAT));
    check("sat_bcnt", 32'(bcnt_w[1]), 32'(SAT));
    drive(0, 0, 0, 32'h0, 0, 0); repeat (4) cycle();
    drive(1, 1, 1, 32'h400, 0, 1); cycle();
    check("clr_bcnt", 32'(bcnt_w[1]), 32'd0);
    check("clr_tcnt", 32'(tcnt_w[1]), 32'd0);
    check("clr_accept_pc_sel", 32'(pc_sel_w[1]), 32'd1);

    // Asynchronous reset while in FLUSH
    drive(0, 0, 0, 32'h0, 0, 0); cycle();
    check("pre_reset_in_flush", {30'd0, ifid_w[1], pc_sel_w[1]}, 32'd2);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_fc%0d_strobes", d + 1),
            {27'd0, pc_sel_w[d], ifid_w[d], idex_w[d], busy_w[d], mis_w[d]}, 32'd0);
      check($sformatf("rst_fc%0d_target", d + 1), tgt_w[d], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    drive(1, 1, 1, 32'h80, 0, 0); cycle();
    check("post_reset_pc_sel", 32'(pc_sel_w[1]), 32'd1);
    check("post_reset_target", tgt_w[1], 32'h80);

    // Random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      drive($urandom_range(9) < 7, $urandom_range(9) < 7, $urandom_range(1) == 1, t,
            $urandom_range(3) == 0, $urandom_range(31) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the PC redirect and pipeline flush that follow a resolved control transfer in EX.
- Consumes the branch decision (branch_or_not) from the branch-condition logic, plus the EX target address.
- Drives the PC mux select, registered target and IF/ID + ID/EX flush strobes for a fixed flush window; keeps saturating branch/taken statistics.

Parameters:
- XLEN, 32, width of PC/target
- FLUSH_CYCLES, 2, cycles flush_ifid stays asserted per redirect (legal 1..7)
- CNT_W, 16, width of statistics counters

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX stage holds a valid instruction
- ex_is_ctrl  input  1  EX instruction is a branch or jal
- branch_or_not  input  1  branch-condition result for EX instruction (1 = taken)
- ex_target  input  XLEN  computed target of EX instruction
- pipe_stall  input  1  pipeline frozen this cycle
- clr_stats  input  1  synchronous clear of both counters
- pc_sel  output  1  1 = PC takes pc_target next edge
- pc_target  output  XLEN  registered redirect target
- flush_ifid  output  1  squash IF/ID register
- flush_idex  output  1  squash ID/EX register
- busy  output  1  redirect/flush sequence in progress
- misalign_err  output  1  one-cycle pulse: taken target with target[1:0] != 0
- branch_cnt  output  CNT_W  accepted control instructions
- taken_cnt  output  CNT_W  accepted, redirected control instructions

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, pc_target 0, counters 0.
- Accept condition (IDLE only): acc = ex_valid & ex_is_ctrl & ~pipe_stall. While pipe_stall=1, nothing is accepted, so a held instruction is counted once.
- FSM states IDLE, REDIRECT, FLUSH.
- IDLE:
  - acc & branch_or_not & target[1:0]==0: latch pc_target <= ex_target; go REDIRECT; branch_cnt++ and taken_cnt++.
  - acc & branch_or_not & target[1:0]!=0: misalign_err=1 next cycle (single pulse); no redirect; branch_cnt++ only.
  - acc & ~branch_or_not: branch_cnt++ only; stay IDLE.
- REDIRECT:
  - pc_sel=1, flush_ifid=1, flush_idex=1, busy=1.
  - If pipe_stall, hold state and all outputs.
  - Else: with FLUSH_CYCLES==1 go IDLE; otherwise load flush counter with FLUSH_CYCLES-1 and go FLUSH.
- FLUSH:
  - flush_ifid=1, busy=1; pc_sel=0, flush_idex=0.
  - Counter decrements only when ~pipe_stall; leave to IDLE when it reaches 0.
- Redirect latency: taken, accepted instruction at edge N gives pc_sel=1 during cycle N+1. busy high for exactly FLUSH_CYCLES unstalled cycles.
- EX inputs are ignored while busy=1; those instructions are squashed bubbles.
- All outputs are registered (Moore); no combinational input-to-output path.
- Counters saturate at 2^CNT_W-1.
- clr_stats clears both counters and wins over a simultaneous increment.
- Reset asserted mid-sequence returns to IDLE immediately and drops all strobes.

Decomposition:
- Shared package branch_ctrl_pkg: FSM state enum (IDLE/REDIRECT/FLUSH, 2-bit) and the XLEN default constant.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice for branch_cnt and taken_cnt.

Test Plan:
- Taken beq: ex_valid=1, ex_is_ctrl=1, branch_or_not=1, ex_target=0x0000_0040 for one cycle -> next cycle pc_sel=1, pc_target=0x40, both flushes=1; following cycle flush_ifid=1 only; then busy=0; branch_cnt=1, taken_cnt=1.
- Not-taken bne: branch_or_not=0 -> no strobes, busy=0; branch_cnt=1, taken_cnt=0.
- Stall during REDIRECT: pipe_stall=1 for 3 cycles right after accept -> pc_sel/flushes held 3 extra cycles; total busy = 2+3 = 5 cycles; taken_cnt increments once.
- Misaligned target 0x0000_0042, taken -> misalign_err pulse exactly one cycle, pc_sel never 1; branch_cnt=1, taken_cnt=0.
- Saturation/clear: CNT_W=4, 20 accepted taken jal -> taken_cnt=15; clr_stats coincident with an accept -> both counters 0.
- Reset mid-FLUSH: rst_n low in FLUSH cycle -> all outputs 0 asynchronously; after release, a new taken branch redirects normally.
